// File: rtl/block_checker_pkg.sv
// Shared types and constants for the keyword-nesting checker: keyword strings,
// pair/token enums, error codes and the word classifier.
package block_checker_pkg;

  localparam int unsigned WORD_CHARS = 7;
  localparam int unsigned WORD_W     = 8 * WORD_CHARS;
  localparam int unsigned LEN_W      = 3;

  localparam logic [7:0] DELIM     = 8'h20;
  localparam logic [7:0] CASE_FOLD = 8'h20;

  // Keywords right-aligned and zero-padded to the word buffer width
  localparam logic [WORD_W-1:0] KW_BEGIN   = {16'h0, "begin"};
  localparam logic [WORD_W-1:0] KW_END     = {32'h0, "end"};
  localparam logic [WORD_W-1:0] KW_CASE    = {24'h0, "case"};
  localparam logic [WORD_W-1:0] KW_ENDCASE = "endcase";
  localparam logic [WORD_W-1:0] KW_FORK    = {24'h0, "fork"};
  localparam logic [WORD_W-1:0] KW_JOIN    = {24'h0, "join"};

  typedef enum logic [1:0] {
    PT_BEGIN = 2'd0,
    PT_CASE  = 2'd1,
    PT_FORK  = 2'd2
  } pair_t;

  typedef enum logic [1:0] {
    TC_NONE  = 2'd0,
    TC_OPEN  = 2'd1,
    TC_CLOSE = 2'd2
  } tok_class_t;

  typedef struct packed {
    tok_class_t cls;
    pair_t      ptype;
  } token_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNDER    = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_OVER     = 2'b11;

  // Bytes are already case-folded and non-zero, so zero padding encodes length
  function automatic token_t classify_word(input logic [WORD_W-1:0] w,
                                           input logic              lng,
                                           input logic [2:0]        en);
    token_t t;
    t.cls   = TC_NONE;
    t.ptype = PT_BEGIN;
    if (!lng) begin
      if (en[0] && w == KW_BEGIN)        begin t.cls = TC_OPEN;  t.ptype = PT_BEGIN; end
      else if (en[0] && w == KW_END)     begin t.cls = TC_CLOSE; t.ptype = PT_BEGIN; end
      else if (en[1] && w == KW_CASE)    begin t.cls = TC_OPEN;  t.ptype = PT_CASE;  end
      else if (en[1] && w == KW_ENDCASE) begin t.cls = TC_CLOSE; t.ptype = PT_CASE;  end
      else if (en[2] && w == KW_FORK)    begin t.cls = TC_OPEN;  t.ptype = PT_FORK;  end
      else if (en[2] && w == KW_JOIN)    begin t.cls = TC_CLOSE; t.ptype = PT_FORK;  end
    end
    return t;
  endfunction

endpackage

// File: rtl/kw_tokenizer.sv
// Word buffer for the nesting checker: folds case, tracks over-long words and
// classifies the partial word every cycle; strobes a commit on the delimiter.
module kw_tokenizer
  import block_checker_pkg::*;
#(
  parameter logic [2:0] PAIR_EN = 3'b111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_char,
  output token_t     o_pend_c,
  output logic       o_commit_c,
  output token_t     o_commit_tok_c
);

  logic [WORD_W-1:0] r_word;
  logic [LEN_W-1:0]  r_len;
  logic              r_long;
  logic              w_delim;

  assign w_delim        = (i_char == DELIM);
  assign o_pend_c       = classify_word(r_word, r_long, PAIR_EN);
  // Empty words from repeated delimiters never strobe
  assign o_commit_c     = i_valid && w_delim && (r_len != '0);
  assign o_commit_tok_c = o_pend_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word <= '0;
      r_len  <= '0;
      r_long <= 1'b0;
    end else if (i_valid) begin
      if (w_delim) begin
        r_word <= '0;
        r_len  <= '0;
        r_long <= 1'b0;
      end else if (r_len == LEN_W'(WORD_CHARS)) begin
        r_long <= 1'b1;
      end else begin
        r_word <= {r_word[WORD_W-9:0], i_char | CASE_FOLD};
        r_len  <= r_len + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/block_checker_multi.sv
// Streaming begin/end, case/endcase, fork/join nesting checker with a typed
// stack, sticky first-error capture and a live tentative "balanced" result.
module block_checker_multi
  import block_checker_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1),
  parameter logic [2:0]  PAIR_EN     = 3'b111
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [DEPTH_W-1:0] depth
);

  localparam int unsigned        IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL  = DEPTH_W'(STACK_DEPTH);

  pair_t              r_stack [STACK_DEPTH];
  logic [DEPTH_W-1:0] r_depth;
  logic               r_error;
  logic [1:0]         r_err_code;

  token_t             w_pend;
  logic               w_commit;
  token_t             w_commit_tok;
  logic [IDX_W-1:0]   w_top_idx;
  pair_t              w_top;
  logic               w_push;
  logic               w_pop;
  logic               w_err_set;
  logic [1:0]         w_err_code;

  kw_tokenizer #(
    .PAIR_EN (PAIR_EN)
  ) u_tok (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_valid        (in_valid),
    .i_char         (in),
    .o_pend_c       (w_pend),
    .o_commit_c     (w_commit),
    .o_commit_tok_c (w_commit_tok)
  );

  assign w_top_idx = (r_depth == '0) ? '0 : IDX_W'(r_depth - DEPTH_W'(1));
  assign w_top     = r_stack[w_top_idx];

  // Commit decision for a completed word; frozen once an error is latched
  always_comb begin
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_err_set  = 1'b0;
    w_err_code = ERR_NONE;
    if (!r_error && w_commit) begin
      case (w_commit_tok.cls)
        TC_OPEN: begin
          if (r_depth == FULL) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_OVER;
          end else begin
            w_push = 1'b1;
          end
        end
        TC_CLOSE: begin
          if (r_depth == '0) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_UNDER;
          end else if (w_top != w_commit_tok.ptype) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_MISMATCH;
          end else begin
            w_pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= PT_BEGIN;
      r_depth    <= '0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_err_set) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_code;
      end
      if (w_push) begin
        r_stack[IDX_W'(r_depth)] <= w_commit_tok.ptype;
        r_depth                  <= r_depth + DEPTH_W'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DEPTH_W'(1);
      end
    end
  end

  // Treat the partial word as if the stream ended now
  always_comb begin
    result = 1'b0;
    if (!r_error) begin
      case (w_pend.cls)
        TC_OPEN:  result = 1'b0;
        TC_CLOSE: result = (r_depth == DEPTH_W'(1)) && (w_top == w_pend.ptype);
        default:  result = (r_depth == '0);
      endcase
    end
  end

  assign error    = r_error;
  assign err_code = r_err_code;
  assign depth    = r_depth;

endmodule

// File: tb/tb_block_checker_multi.sv
// Bench for block_checker_multi: three configurations share one character stream
// and are compared beat by beat against a string/queue reference model.
module tb_block_checker_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_ch;

  always #5 clk = ~clk;

  logic       res0, res1, res2;
  logic       err0, err1, err2;
  logic [1:0] ec0, ec1, ec2;
  logic [4:0] dep0;
  logic [2:0] dep1;
  logic [4:0] dep2;

  block_checker_multi #(.STACK_DEPTH(16), .PAIR_EN(3'b111)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(in_ch),
    .result(res0), .error(err0), .err_code(ec0), .depth(dep0));
  block_checker_multi #(.STACK_DEPTH(4), .PAIR_EN(3'b111)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(in_ch),
    .result(res1), .error(err1), .err_code(ec1), .depth(dep1));
  block_checker_multi #(.STACK_DEPTH(16), .PAIR_EN(3'b001)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(in_ch),
    .result(res2), .error(err2), .err_code(ec2), .depth(dep2));

  logic       o_res [3];
  logic       o_err [3];
  logic [1:0] o_ec  [3];
  logic [8:0] o_dep [3];

  assign o_res[0] = res0;  assign o_res[1] = res1;  assign o_res[2] = res2;
  assign o_err[0] = err0;  assign o_err[1] = err1;  assign o_err[2] = err2;
  assign o_ec[0]  = ec0;   assign o_ec[1]  = ec1;   assign o_ec[2]  = ec2;
  assign o_dep[0] = 9'(dep0);
  assign o_dep[1] = 9'(dep1);
  assign o_dep[2] = 9'(dep2);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word as a string, stack as a queue of pair indices
  string opens  [3] = '{"begin", "case", "fork"};
  string closes [3] = '{"end", "endcase", "join"};
  string fillers[8] = '{"x", "endx", "ab", "endcasex", "beginxyz", "forks", "jo", "q1"};
  int       lim [3] = '{16, 4, 16};
  bit [2:0] ens [3] = '{3'b111, 3'b111, 3'b001};

  int    stk [3][$];
  bit    merr[3];
  int    mcode[3];
  string mword;

  function automatic void m_classify(input string w, input bit [2:0] en,
                                     output int cls, output int typ);
    cls = 0;
    typ = 0;
    if (w.len() <= 7) begin
      for (int k = 0; k < 3; k++) begin
        if (en[k] && w == opens[k])  begin cls = 1; typ = k; end
        if (en[k] && w == closes[k]) begin cls = 2; typ = k; end
      end
    end
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < 3; c++) begin
      stk[c].delete();
      merr[c]  = 1'b0;
      mcode[c] = 0;
    end
    mword = "";
  endfunction

  function automatic void m_commit(input int c);
    int cls, typ;
    m_classify(mword, ens[c], cls, typ);
    if (merr[c]) return;
    if (cls == 1) begin
      if (stk[c].size() == lim[c]) begin merr[c] = 1'b1; mcode[c] = 3; end
      else stk[c].push_back(typ);
    end else if (cls == 2) begin
      if (stk[c].size() == 0)        begin merr[c] = 1'b1; mcode[c] = 1; end
      else if (stk[c][$] != typ)     begin merr[c] = 1'b1; mcode[c] = 2; end
      else void'(stk[c].pop_back());
    end
  endfunction

  function automatic void m_char(input logic [7:0] ch);
    if (ch == 8'h20) begin
      if (mword.len() > 0) for (int c = 0; c < 3; c++) m_commit(c);
      mword = "";
    end else begin
      mword = $sformatf("%s%c", mword, ch | 8'h20);
    end
  endfunction

  function automatic bit m_result(input int c);
    int cls, typ;
    if (merr[c]) return 1'b0;
    m_classify(mword, ens[c], cls, typ);
    if (cls == 1) return 1'b0;
    if (cls == 2) return (stk[c].size() == 1) && (stk[c][$] == typ);
    return stk[c].size() == 0;
  endfunction

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("result%0d", c), 32'(o_res[c]), 32'(m_result(c)));
      chk($sformatf("error%0d", c),  32'(o_err[c]), 32'(merr[c]));
      chk($sformatf("errcode%0d", c), 32'(o_ec[c]), 32'(mcode[c]));
      chk($sformatf("depth%0d", c),  32'(o_dep[c]), 32'(stk[c].size()));
    end
  endtask

  task automatic beat(input logic [7:0] ch, input bit v);
    @(negedge clk);
    in_valid = v;
    in_ch    = ch;
    @(posedge clk);
    #1;
    if (v) m_char(ch);
    check_all();
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) beat(8'($urandom_range(65, 90)), 1'b0);
      beat(8'(s[i]), 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    m_reset();
    check_all();
    #1;
    reset_n = 1'b1;
  endtask

  function automatic string casefuzz(input string s);
    string out = "";
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] b;
      b = 8'(s[i]);
      if ($urandom_range(0, 1) == 1 && b >= 8'h61 && b <= 8'h7a) b = b & 8'hdf;
      out = $sformatf("%s%c", out, b);
    end
    return out;
  endfunction

  task automatic rand_segment(input int nwords);
    int gstk[$];
    for (int w = 0; w < nwords; w++) begin
      int    r;
      int    k;
      string s;
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 2);
      if (r < 40) begin
        s = opens[k];
        gstk.push_back(k);
      end else if (r < 80 && gstk.size() > 0) begin
        int t;
        t = gstk.pop_back();
        if (r >= 76) t = (t + 1) % 3;
        s = closes[t];
      end else if (r < 90) begin
        s = closes[k];
      end else begin
        s = fillers[$urandom_range(0, 7)];
      end
      send_str(casefuzz(s), 1'($urandom_range(0, 1)));
      if (w != nwords - 1 || $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 2)) beat(8'h20, 1'b1);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_ch    = 8'h00;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    chk("rst_result", 32'(res0), 32'd1);
    chk("rst_depth",  32'(dep0), 32'd0);
    chk("rst_errcode", 32'(ec0), 32'd0);
    reset_n = 1'b1;

    send_str("begin case x endcase end ", 1'b0);
    chk("nest_depth",  32'(dep0), 32'd0);
    chk("nest_result", 32'(res0), 32'd1);
    chk("nest_error",  32'(err0), 32'd0);

    do_reset();
    send_str("begin endcase ", 1'b0);
    chk("mismatch_code", 32'(ec0), 32'd2);
    send_str("end ", 1'b0);
    chk("frozen_depth",  32'(dep0), 32'd1);
    chk("frozen_result", 32'(res0), 32'd0);

    do_reset();
    send_str("end", 1'b0);
    chk("pend_close_result", 32'(res0), 32'd0);
    send_str(" ", 1'b0);
    chk("underflow_code", 32'(ec0), 32'd1);
    do_reset();
    chk("midreset_result", 32'(res0), 32'd1);
    chk("midreset_depth",  32'(dep0), 32'd0);

    repeat (5) send_str("fork ", 1'b0);
    chk("overflow_depth", 32'(dep1), 32'd4);
    chk("overflow_code",  32'(ec1),  32'd3);
    chk("deep_depth",     32'(dep0), 32'd5);

    do_reset();
    send_str("BeGiN endx begin", 1'b1);
    chk("gap_depth",  32'(dep0), 32'd1);
    chk("gap_result", 32'(res0), 32'd0);
    chk("gap_error",  32'(err0), 32'd0);

    do_reset();
    send_str("case end ", 1'b0);
    chk("pair_en_code", 32'(ec2), 32'd1);
    chk("all_en_code",  32'(ec0), 32'd2);

    do_reset();
    send_str("endcasex begin endcas end  join ", 1'b1);

    for (int seg = 0; seg < 40; seg++) begin
      do_reset();
      rand_segment($urandom_range(4, 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_checker_multi.md
Name: block_checker_multi

Overview:
- Streaming keyword-nesting checker. Consumes one ASCII character per accepted beat and tracks nesting of three keyword pairs: begin/end, case/endcase, fork/join.
- Pairs must nest properly across types, so a type stack replaces a bare counter.
- Reports a live "balanced so far" result plus a sticky error with cause. Sits on the character stream of the text-checking datapath.

Parameters:
- STACK_DEPTH, 16, maximum nesting depth, from 2 to 256.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth output.
- PAIR_EN, 3'b111, per-pair enable. Bit0 is begin/end, bit1 case/endcase, bit2 fork/join. A disabled pair's keywords are plain words.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  the in character is presented this cycle.
- in  in  8  ASCII character.
- result  out  1  the stream so far, taken as ending now, is balanced and error-free.
- error  out  1  sticky nesting error.
- err_code  out  2  00 none, 01 underflow, 10 type mismatch, 11 overflow. Holds the first error.
- depth  out  DEPTH_W  current committed stack depth.

Behaviour:
- Reset (async assert, sync deassert to clk) clears the stack, depth, word buffer and error. After reset: result=1, error=0, err_code=00, depth=0.
- A character is consumed only on a clk edge with in_valid=1. With in_valid=0 all state holds.
- Tokenising:
  - Delimiter is 0x20 only. Any other byte is a word character.
  - Letters compare case-insensitively: OR with 0x20 before compare.
  - The word buffer holds 7 chars, the longest keyword being endcase.
  - An 8th char sets a "long" flag and the word can no longer match.
  - A delimiter completes the word, which is then classified, and clears the buffer.
  - Consecutive delimiters produce empty words, which are ignored.
- Commit on word completion, in the same cycle the delimiter is accepted:
  - Open keyword: push its 2-bit type. If depth==STACK_DEPTH, set error with overflow instead.
  - Close keyword with depth==0: error, underflow.
  - Close keyword whose type differs from the top of stack: error, type mismatch.
  - Close keyword whose type matches: pop.
  - Non-keyword: no effect.
- Error is sticky. Once set, the stack, depth and err_code freeze, further input is ignored, and result=0 until reset.
- result is combinational from state. It treats the partial word in the buffer as if completed:
  - error=1 -> 0.
  - Pending open keyword -> 0.
  - Pending close keyword -> 1 only if depth==1 and its type matches the top of stack.
  - Otherwise -> (depth==0).
- Tentative evaluation means these must hold:
  - "end" followed by "x" makes the word a non-keyword, so result re-evaluates.
  - "end" is a prefix of "endcase", so the pending class is recomputed on every char.
- Latency: committed state updates on the accepting edge. result reflects the accepted char immediately after that edge.
- Mid-stream reset_n assertion: outputs return to reset values asynchronously. No partial word survives.

Decomposition:
- Package block_checker_pkg holds:
  - the keyword byte-string constants (lower case);
  - the 2-bit pair-type enum (BEGIN, CASE, FORK);
  - the token-class enum (NONE, OPEN, CLOSE) with its type field;
  - the err_code constants.
- Sub-module kw_tokenizer (block_checker_pkg users only) owns the word buffer and long flag. It outputs:
  - the pending class and type, combinationally, for the current partial word;
  - a one-cycle commit strobe with the class and type when a delimiter completes a word.
- The top level owns the stack array, depth, error logic and result.

Test Plan:
- Stream "begin case x endcase end " -> depth steps 1,2,1,0. result=1 at the end, error=0.
- Stream "begin endcase " -> error=1, err_code=10 on the delimiter after endcase. result stays 0. Later "end " is ignored and depth stays 1.
- Stream "end" without a trailing space:
  - result=0 while the partial word is incomplete (depth 0, close pending).
  - The following space sets err_code=01.
  - Pulse reset_n low -> result=1, depth=0.
- STACK_DEPTH=4: five "fork " -> depth 4, then err_code=11 on the fifth delimiter, depth stays 4.
- Stream "BeGiN endx begin" with in_valid gaps -> depth=1. Gaps hold all state. "endx" is a non-keyword. result=0.
- PAIR_EN=3'b001: "case end " -> err_code=01. With PAIR_EN=3'b111 the same stream gives err_code=10.
